vend_controller: RTL and testbench
==================================

# vend_controller

Multi-item vending controller sequencing a shared dispenser motor and coin-change hopper. Accumulates inserted coins into a credit register, validates item selections against programmable prices, runs a request/acknowledge handshake with the dispenser, and returns change one coin per cycle. It sits between the coin acceptor and selection keypad on one side and the dispenser and hopper actuators on the other, replacing the fixed single-price FSM.

## Interface
- NUM_ITEMS, 4, number of selectable items; width of item index IW = $clog2(NUM_ITEMS)
- CREDIT_W, 8, credit and price width in cents; MAX_CREDIT = 2**CREDIT_W-1
- DEFAULT_PRICE, 75, reset price for every item (cents)
- TIMEOUT_CYC, 1000, cycles to wait for disp_ack before aborting
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- coin_valid  in  1  one-cycle coin insertion strobe
- coin_type  in  2  0 = nickel (5), 1 = dime (10), 2 = quarter (25), 3 = dollar (100)
- sel_valid  in  1  one-cycle selection strobe
- sel_item  in  IW  selected item index
- cancel  in  1  one-cycle refund request
- cfg_we  in  1  price write strobe
- cfg_addr  in  IW  item index for price write
- cfg_price  in  CREDIT_W  new price in cents
- disp_ack  in  1  one-cycle pulse from dispenser: item delivered
- disp_req  out  1  held high while a dispense is pending
- disp_item  out  IW  item being dispensed; stable while disp_req is high
- change_q / change_d / change_n  out  1 each  one-cycle pulse: eject a quarter, dime, or nickel
- credit  out  CREDIT_W  current credit
- busy  out  1  high whenever the state is not IDLE
- sel_nack  out  1  pulse: selection refused
- coin_reject  out  1  pulse: coin refused and diverted to the return chute
- vend_done  out  1  pulse: dispense completed
- fault  out  1  pulse: dispenser timeout

## Operation
- States: IDLE, DISPENSE, CHANGE.
- Reset: state IDLE, credit 0, all prices DEFAULT_PRICE, timer 0, every output 0.
- IDLE, per-cycle priority is cancel > sel_valid > coin_valid:
  - **cancel:** if credit > 0, go to CHANGE; otherwise no effect. A coin in the same cycle is rejected and a selection in the same cycle is ignored.
  - **sel_valid:** accepted if sel_item < NUM_ITEMS and credit >= price[sel_item]. On acceptance, latch disp_item, go to DISPENSE, and reject any coin in that cycle. On refusal, pulse sel_nack and still evaluate the coin.
  - **coin_valid:** add the coin value to credit. If the sum exceeds MAX_CREDIT, leave credit unchanged and pulse coin_reject.
  - **cfg_we:** write the price only when in IDLE with credit == 0 and no cancel, sel_valid, or coin_valid in that cycle. Ignore the write otherwise.
- DISPENSE:
  - disp_req is high and the timer counts up.
  - On disp_ack: credit -= price[disp_item], pulse vend_done, drop disp_req. Go to CHANGE if the remaining credit >= 5, else to IDLE with credit cleared.
  - If the timer reaches TIMEOUT_CYC-1 without an ack: pulse fault, drop disp_req, leave credit undeducted, go to CHANGE (full refund).
- CHANGE:
  - Each cycle, emit exactly one coin using greedy order: quarter if credit >= 25, else dime if >= 10, else nickel if >= 5. Decrement credit in the same cycle.
  - When credit < 5, clear credit (remainder forfeited) and go to IDLE with no pulse that cycle.
- DISPENSE and CHANGE:
  - coin_valid pulses coin_reject.
  - sel_valid, cancel, cfg_we, and a disp_ack arriving outside DISPENSE are ignored.
- Arithmetic: all credit and price operations are unsigned CREDIT_W-bit. Subtraction cannot underflow because acceptance guarantees credit >= price.

## Timing
- All outputs are registered and update on the edge following the causing input.
- Selection accepted at edge N: disp_req is high from N+1.
- disp_ack sampled at edge M: vend_done and the credit update appear at M+1, and disp_req is low from M+1.
- CHANGE: first coin pulse in the cycle after entry, one pulse per cycle, back in IDLE one cycle after the last pulse.
- Coin accepted at edge N: credit is updated from N+1, so a selection at edge N+1 sees the new credit.
- rst mid-operation: immediate return to reset values. Pending credit is discarded and disp_req drops at the next edge.

## Structure
- Package vend_pkg: state_t enum (IDLE, DISPENSE, CHANGE), coin_t enum, coin value constants (5/10/25/100), coin_value() function.
- Sub-module vend_change_unit: combinational greedy selector; takes credit and produces the one-hot coin choice and the decremented credit.
- Top module holds the FSM, credit register, price register file, and timeout counter.

## Test plan
- Insert quarter ×3 into item 0 (price 75), select 0, ack after 3 cycles: disp_req high for 3 cycles, vend_done, credit 0, no change pulses.
- Insert dollar, select item 0 (75): after ack, change_q pulses once, credit returns to 0, state IDLE.
- Insert dime, select item 1 (75): sel_nack, credit stays 10. Then cancel: change_d pulses once, credit 0.
- Program item 2 to 40, insert dollar, select 2, ack: change pulses q, q, d in consecutive cycles, then IDLE.
- Insert quarter, select item 0 with price 25, never ack: fault pulses at TIMEOUT_CYC, change_q refunds, credit 0.
- Same-cycle sel_valid and coin_valid with sufficient credit: selection accepted and coin_reject pulses. Credit of 250 plus a dime: coin_reject, credit stays 250. rst asserted during CHANGE: all outputs 0 next cycle.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and coin constants for the multi-item vending controller.
package vend_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DISPENSE,
    CHANGE
  } state_t;

  typedef enum logic [1:0] {
    COIN_NICKEL,
    COIN_DIME,
    COIN_QUARTER,
    COIN_DOLLAR
  } coin_t;

  localparam int unsigned VAL_NICKEL  = 5;
  localparam int unsigned VAL_DIME    = 10;
  localparam int unsigned VAL_QUARTER = 25;
  localparam int unsigned VAL_DOLLAR  = 100;

  function automatic logic [6:0] coin_value(coin_t c);
    logic [6:0] v;
    unique case (c)
      COIN_NICKEL:  v = 7'(VAL_NICKEL);
      COIN_DIME:    v = 7'(VAL_DIME);
      COIN_QUARTER: v = 7'(VAL_QUARTER);
      default:      v = 7'(VAL_DOLLAR);
    endcase
    return v;
  endfunction

endpackage

// File: rtl/vend_change_unit.sv
// Greedy change selector: picks the largest coin not exceeding credit
// and returns the credit left after ejecting it.
module vend_change_unit
  import vend_pkg::*;
#(
  parameter int CREDIT_W = 8
) (
  input  logic [CREDIT_W-1:0] credit,
  output logic                give_q,
  output logic                give_d,
  output logic                give_n,
  output logic [CREDIT_W-1:0] credit_next
);

  localparam logic [CREDIT_W-1:0] Q = CREDIT_W'(VAL_QUARTER);
  localparam logic [CREDIT_W-1:0] D = CREDIT_W'(VAL_DIME);
  localparam logic [CREDIT_W-1:0] N = CREDIT_W'(VAL_NICKEL);

  logic ge_q, ge_d, ge_n;

  assign ge_q = credit >= Q;
  assign ge_d = credit >= D;
  assign ge_n = credit >= N;

  always_comb begin
    give_q      = 1'b0;
    give_d      = 1'b0;
    give_n      = 1'b0;
    credit_next = credit;
    unique case (1'b1)
      ge_q: begin
        give_q      = 1'b1;
        credit_next = credit - Q;
      end
      ge_d && !ge_q: begin
        give_d      = 1'b1;
        credit_next = credit - D;
      end
      ge_n && !ge_d: begin
        give_n      = 1'b1;
        credit_next = credit - N;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/vend_controller.sv
// Multi-item vending controller: credit, programmable prices,
// dispenser handshake with timeout, and one-coin-per-cycle change.
module vend_controller
  import vend_pkg::*;
#(
  parameter  int NUM_ITEMS     = 4,
  parameter  int CREDIT_W      = 8,
  parameter  int DEFAULT_PRICE = 75,
  parameter  int TIMEOUT_CYC   = 1000,
  localparam int IW = (NUM_ITEMS > 1) ? $clog2(NUM_ITEMS) : 1,
  localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                coin_valid,
  input  logic [1:0]          coin_type,
  input  logic                sel_valid,
  input  logic [IW-1:0]       sel_item,
  input  logic                cancel,
  input  logic                cfg_we,
  input  logic [IW-1:0]       cfg_addr,
  input  logic [CREDIT_W-1:0] cfg_price,
  input  logic                disp_ack,
  output logic                disp_req,
  output logic [IW-1:0]       disp_item,
  output logic                change_q,
  output logic                change_d,
  output logic                change_n,
  output logic [CREDIT_W-1:0] credit,
  output logic                busy,
  output logic                sel_nack,
  output logic                coin_reject,
  output logic                vend_done,
  output logic                fault
);

  state_t              state;
  logic [CREDIT_W-1:0] prices [NUM_ITEMS];
  logic [TW-1:0]       timer;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] left;
  logic                sel_ok, cfg_ok;
  logic                cq, cd, cn;
  logic [CREDIT_W-1:0] chg_credit;

  vend_change_unit #(.CREDIT_W(CREDIT_W)) u_change (
    .credit      (credit),
    .give_q      (cq),
    .give_d      (cd),
    .give_n      (cn),
    .credit_next (chg_credit)
  );

  // Extra top bit flags a sum beyond MAX_CREDIT
  assign coin_sum = {1'b0, credit}
                  + (CREDIT_W+1)'(coin_value(coin_t'(coin_type)));
  assign sel_ok   = (32'(sel_item) < NUM_ITEMS)
                  && (credit >= prices[sel_item]);
  assign cfg_ok   = 32'(cfg_addr) < NUM_ITEMS;
  assign left     = credit - prices[disp_item];
  assign disp_req = state == DISPENSE;
  assign busy     = state != IDLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      credit      <= '0;
      timer       <= '0;
      disp_item   <= '0;
      change_q    <= 1'b0;
      change_d    <= 1'b0;
      change_n    <= 1'b0;
      sel_nack    <= 1'b0;
      coin_reject <= 1'b0;
      vend_done   <= 1'b0;
      fault       <= 1'b0;
      for (int i = 0; i < NUM_ITEMS; i++)
        prices[i] <= CREDIT_W'(DEFAULT_PRICE);
    end else begin
      change_q    <= 1'b0;
      change_d    <= 1'b0;
      change_n    <= 1'b0;
      sel_nack    <= 1'b0;
      coin_reject <= 1'b0;
      vend_done   <= 1'b0;
      fault       <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cancel) begin
            coin_reject <= coin_valid;
            if (credit != '0)
              state <= CHANGE;
          end else if (sel_valid && sel_ok) begin
            coin_reject <= coin_valid;
            disp_item   <= sel_item;
            timer       <= '0;
            state       <= DISPENSE;
          end else begin
            sel_nack <= sel_valid;
            if (coin_valid) begin
              if (coin_sum[CREDIT_W])
                coin_reject <= 1'b1;
              else
                credit <= coin_sum[CREDIT_W-1:0];
            end else if (cfg_we && !sel_valid
                         && credit == '0 && cfg_ok) begin
              prices[cfg_addr] <= cfg_price;
            end
          end
        end
        DISPENSE: begin
          coin_reject <= coin_valid;
          if (disp_ack) begin
            vend_done <= 1'b1;
            if (left >= CREDIT_W'(VAL_NICKEL)) begin
              credit <= left;
              state  <= CHANGE;
            end else begin
              credit <= '0;
              state  <= IDLE;
            end
          end else if (timer == TW'(TIMEOUT_CYC-1)) begin
            fault <= 1'b1;
            state <= CHANGE;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        CHANGE: begin
          coin_reject <= coin_valid;
          change_q    <= cq;
          change_d    <= cd;
          change_n    <= cn;
          // Sub-nickel remainder is forfeited on exit
          if (cq || cd || cn) begin
            credit <= chg_credit;
          end else begin
            credit <= '0;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_controller.sv
// Randomized + directed bench for vend_controller against a
// transaction-level credit/refund model.
module tb_vend_controller;

  localparam int TO = 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       coin_valid = 1'b0;
  logic [1:0] coin_type = '0;
  logic       sel_valid = 1'b0;
  logic [1:0] sel_item = '0;
  logic       cancel = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_addr = '0;
  logic [7:0] cfg_price = '0;
  logic       disp_ack = 1'b0;
  logic       disp_req;
  logic [1:0] disp_item;
  logic       change_q, change_d, change_n;
  logic [7:0] credit;
  logic       busy, sel_nack, coin_reject, vend_done, fault;

  vend_controller #(.TIMEOUT_CYC(TO)) dut (
    .clk         (clk),
    .rst         (rst),
    .coin_valid  (coin_valid),
    .coin_type   (coin_type),
    .sel_valid   (sel_valid),
    .sel_item    (sel_item),
    .cancel      (cancel),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_price   (cfg_price),
    .disp_ack    (disp_ack),
    .disp_req    (disp_req),
    .disp_item   (disp_item),
    .change_q    (change_q),
    .change_d    (change_d),
    .change_n    (change_n),
    .credit      (credit),
    .busy        (busy),
    .sel_nack    (sel_nack),
    .coin_reject (coin_reject),
    .vend_done   (vend_done),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  localparam int M_IDLE   = 0;
  localparam int M_DISP   = 1;
  localparam int M_REFUND = 2;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  int m_mode = M_IDLE;
  int m_credit = 0;
  int m_price [4] = '{75, 75, 75, 75};
  int m_item = 0;
  int m_left = 0;
  int m_coins [$];
  bit e_q, e_d, e_n, e_nack, e_rej, e_done, e_fault;
  bit hang = 1'b0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               tag, got, exp, cyc);
    end
  endtask

  function automatic int val_of(logic [1:0] t);
    case (t)
      2'd0:    return 5;
      2'd1:    return 10;
      2'd2:    return 25;
      default: return 100;
    endcase
  endfunction

  // Whole refund planned up front as a list of coins.
  task automatic start_refund();
    int c;
    c = m_credit;
    m_coins.delete();
    repeat (c / 25) m_coins.push_back(25);
    c = c % 25;
    repeat (c / 10) m_coins.push_back(10);
    c = c % 10;
    repeat (c / 5) m_coins.push_back(5);
    m_mode = M_REFUND;
  endtask

  task automatic model_step();
    int v;
    {e_q, e_d, e_n, e_nack, e_rej, e_done, e_fault} = '0;
    if (rst) begin
      m_mode = M_IDLE;
      m_credit = 0;
      m_price = '{75, 75, 75, 75};
      m_coins.delete();
      return;
    end
    if (m_mode != M_IDLE && coin_valid) e_rej = 1'b1;
    case (m_mode)
      M_IDLE: begin
        if (cancel) begin
          e_rej = coin_valid;
          if (m_credit > 0) start_refund();
        end else if (sel_valid && m_credit >= m_price[sel_item]) begin
          e_rej  = coin_valid;
          m_item = int'(sel_item);
          m_left = TO;
          m_mode = M_DISP;
        end else begin
          e_nack = sel_valid;
          if (coin_valid) begin
            v = val_of(coin_type);
            if (m_credit + v > 255) e_rej = 1'b1;
            else m_credit += v;
          end else if (cfg_we && !sel_valid && m_credit == 0) begin
            m_price[cfg_addr] = int'(cfg_price);
          end
        end
      end
      M_DISP: begin
        if (disp_ack) begin
          e_done = 1'b1;
          m_credit -= m_price[m_item];
          if (m_credit >= 5) start_refund();
          else begin
            m_credit = 0;
            m_mode = M_IDLE;
          end
        end else if (m_left == 1) begin
          e_fault = 1'b1;
          start_refund();
        end else begin
          m_left--;
        end
      end
      default: begin
        if (m_coins.size() > 0) begin
          v = m_coins.pop_front();
          m_credit -= v;
          e_q = (v == 25);
          e_d = (v == 10);
          e_n = (v == 5);
        end else begin
          m_credit = 0;
          m_mode = M_IDLE;
        end
      end
    endcase
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    cyc++;
    chk("credit", 32'(credit), 32'(m_credit));
    chk("pulses q/d/n/nack/rej/done/fault",
        32'({change_q, change_d, change_n, sel_nack,
             coin_reject, vend_done, fault}),
        32'({e_q, e_d, e_n, e_nack, e_rej, e_done, e_fault}));
    chk("disp_req", 32'(disp_req), 32'(m_mode == M_DISP));
    chk("busy", 32'(busy), 32'(m_mode != M_IDLE));
    if (m_mode == M_DISP)
      chk("disp_item", 32'(disp_item), 32'(m_item));
    {rst, coin_valid, sel_valid, cancel, cfg_we, disp_ack} = '0;
  endtask

  task automatic coin(input logic [1:0] t);
    coin_valid = 1'b1;
    coin_type  = t;
    step();
  endtask

  task automatic sel(input logic [1:0] i);
    sel_valid = 1'b1;
    sel_item  = i;
    step();
  endtask

  task automatic ack();
    disp_ack = 1'b1;
    step();
  endtask

  task automatic do_cancel();
    cancel = 1'b1;
    step();
  endtask

  task automatic cfg(input logic [1:0] a, input logic [7:0] p);
    cfg_we    = 1'b1;
    cfg_addr  = a;
    cfg_price = p;
    step();
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  initial begin
    rst = 1'b1;
    step();
    idle(1);

    repeat (3) coin(2);
    sel(0);
    idle(2);
    ack();
    idle(2);

    coin(3);
    sel(0);
    idle(1);
    ack();
    idle(3);

    coin(1);
    sel(1);
    do_cancel();
    idle(3);

    cfg(2, 8'd40);
    coin(3);
    sel(2);
    ack();
    idle(5);

    coin(3);
    coin(3);
    coin(2);
    coin(2);
    coin(1);
    do_cancel();
    idle(12);

    coin(3);
    sel_valid = 1'b1;
    sel_item  = 0;
    coin_valid = 1'b1;
    coin_type = 2'd0;
    step();
    ack();
    idle(3);

    coin(3);
    do_cancel();
    idle(1);
    rst = 1'b1;
    step();
    idle(2);

    cfg(0, 8'd25);
    coin(2);
    sel(0);
    idle(TO + 3);

    for (int k = 0; k < 12000; k++) begin
      rst        = ($urandom_range(0, 1999) == 0);
      cancel     = ($urandom_range(0, 39) == 0);
      coin_valid = ($urandom_range(0, 3) == 0);
      coin_type  = 2'($urandom_range(0, 3));
      if (cancel && m_credit == 0) coin_valid = 1'b0;
      sel_valid  = ($urandom_range(0, 9) == 0);
      sel_item   = 2'($urandom_range(0, 3));
      if (sel_valid && m_mode == M_IDLE)
        hang = ($urandom_range(0, 30) == 0);
      cfg_we     = ($urandom_range(0, 4) == 0);
      cfg_addr   = 2'($urandom_range(0, 3));
      cfg_price  = ($urandom_range(0, 9) == 0)
                 ? 8'($urandom_range(0, 255))
                 : 8'($urandom_range(1, 30) * 5);
      if (m_mode == M_DISP)
        disp_ack = hang ? 1'b0 : ($urandom_range(0, 4) == 0);
      else
        disp_ack = ($urandom_range(0, 49) == 0);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
